// File: rtl/bcd_serial_adder.sv
// Packed-BCD adder that walks the operands one decimal digit per clock, LSD first,
// with a start/busy/done handshake and a registered carry between digits.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry, r_cout, r_busy, r_done, r_err;

    logic [4:0]      w_raw;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic            w_err_in;
    logic            w_last;

    // Operand registers shift right each step, so the current digit is always [3:0].
    always_comb begin
        w_raw   = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
        w_gt9   = (w_raw > 5'd9);
        w_digit = w_gt9 ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
        w_last  = (r_idx == IW'(DIGITS - 1));
    end

    always_comb begin
        w_err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) w_err_in = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= w_err_in;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_gt9;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IW'(i)) r_sum[4*i +: 4] <= w_digit;
                    end
                    if (w_last) begin
                        r_cout  <= w_gt9;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: table vectors plus random decimal sums, checked by a
// done-triggered scoreboard, and hand sequences for handshake and reset corners.
module tb_bcd_serial_adder;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout, busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum",  32'(sum),  32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("err",  32'(err),  32'(e.err));
            end
        end
    end

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic push(input logic [W-1:0] s, input logic c, input logic e);
        exp_t x;
        x.sum = s; x.cout = c; x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'(done), 32'(1));
    endtask

    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] s, input logic c, input logic e);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        push(s, c, e);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("op");
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        tbl[3] = '{16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
        tbl[4] = '{16'h00A3, 16'h0001, 1'b0, 16'h0104, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};

        #12;
        chk("rst_sum",  32'(sum),  32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err",  32'(err),  32'(0));
        @(negedge clk); rst_n = 1'b1;

        // Latency of the first vector: busy after edges k..k+3, done after k+4.
        @(negedge clk);
        a = tbl[0].a; b = tbl[0].b; cin = tbl[0].cin; start = 1'b1;
        push(tbl[0].sum, tbl[0].cout, tbl[0].err);
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            chk("lat_busy", 32'(busy), 32'(1));
            chk("lat_nodone", 32'(done), 32'(0));
            @(posedge clk); #1;
        end
        chk("lat_busy_off", 32'(busy), 32'(0));
        chk("lat_done", 32'(done), 32'(1));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'(0));

        for (int i = 1; i < 7; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].err);

        // Results hold through idle cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum",  32'(sum),  32'(tbl[6].sum));
        chk("hold_cout", 32'(cout), 32'(tbl[6].cout));

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            int           t;
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(9));
                rb[4*d +: 4] = 4'($urandom_range(9));
            end
            rc = 1'($urandom_range(1));
            t  = bcd2int(ra) + bcd2int(rb) + int'(rc);
            do_op(ra, rb, rc, int2bcd(t), (t >= 10000), 1'b0);
        end

        // Start during ADD with other operands is ignored.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
        push(16'h5432, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore");
        @(posedge clk); #1;
        chk("ignore_idle", 32'(busy), 32'(0));

        // Start held high into the DONE cycle launches the next op directly.
        @(negedge clk);
        a = 16'h0505; b = 16'h0505; cin = 1'b0; start = 1'b1;
        push(16'h1010, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 16'h2468; b = 16'h1357; cin = 1'b1;
        push(16'h3826, 1'b0, 1'b0);
        wait_done("b2b_first");
        @(posedge clk); #1;
        chk("b2b_busy", 32'(busy), 32'(1));
        chk("b2b_done", 32'(done), 32'(0));
        start = 1'b0;
        wait_done("b2b_second");
        @(posedge clk); #1;

        // Asynchronous reset two edges into an op with an invalid digit.
        @(negedge clk);
        a = 16'h00B7; b = 16'h0222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_err", 32'(err), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",  32'(sum),  32'(0));
        chk("mid_rst_cout", 32'(cout), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_err",  32'(err),  32'(0));
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'(0));
        do_op(16'h0123, 16'h0877, 1'b0, 16'h1000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder.
- Sequential front-end that walks two DIGITS-wide packed-BCD operands one decimal digit per clock, least-significant digit first.
- Each step performs the single-digit BCD add with carry and decimal correction, and ripples the carry through a register.
- Sits upstream of the result/display path and produces a full-width BCD sum with a start/busy/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); data width is 4*DIGITS.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry-in to digit 0.
- sum  output  4*DIGITS  packed-BCD result, registered.
- cout  output  1  decimal carry out of the top digit, registered.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/cout are final.
- err  output  1  at least one input digit of the current operation was >9.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; sum=0, cout=0, busy=0, done=0, err=0; digit index=0; carry register=0.
- States: IDLE, ADD, DONE.
- IDLE: start=1 at edge k →
  - latch a, b into operand registers; carry←cin; index←0;
  - sum←0, cout←0;
  - err←(any digit of a or b >9);
  - busy←1; state←ADD.
- ADD, each edge:
  - raw = a_d + b_d + carry as a 5-bit value, 0..31.
  - If raw>9: digit=(raw+6)[3:0], carry←1. Else: digit=raw[3:0], carry←0.
  - Write digit into sum[4*idx+3:4*idx]; idx←idx+1.
  - Rule applies unchanged to invalid digits, so the output is deterministic.
- Last digit (idx=DIGITS-1), on the same edge:
  - cout←new carry; busy←0; done←1; state←DONE.
- Latency: start sampled at edge k → done high in the cycle after edge k+DIGITS (DIGITS+1 edges from start to done deasserting).
- DONE: lasts exactly one cycle.
  - start=1 → same acceptance as IDLE, which allows back-to-back operations; done←0.
  - Otherwise → IDLE, done←0.
- start while busy (ADD): ignored; operands and progress unaffected.
- Input changes after acceptance: ignored (operands are registered).
- sum, cout, err: hold their values from the end of an operation until the next start is accepted.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); no done pulse.
- Index counter width: clog2(DIGITS), minimum 1 bit. No wrap beyond DIGITS-1.

Test Plan:
- DIGITS=4, a=16'h1234, b=16'h5678, cin=0, start pulse at edge k:
  - busy=1 for edges k..k+3;
  - done=1 for one cycle after edge k+4;
  - sum=16'h6912, cout=0, err=0.
- a=16'h9999, b=16'h0001, cin=0 → sum=16'h0000, cout=1 (full carry ripple through all digits).
- a=16'h9999, b=16'h9999, cin=1 → sum=16'h9999, cout=1. Also a=16'h0999, b=16'h0001, cin=1 → sum=16'h1001, cout=0.
- a=16'h00A3, b=16'h0001, cin=0 → err=1.
  - Digit 0 = 4 (raw 4).
  - Digit 1: raw 10 → digit 0 with carry.
  - Final sum=16'h0104, cout=0.
- Busy and back-to-back handling:
  - start re-pulsed during ADD with different operands → ignored; first result unchanged.
  - start held high in the DONE cycle → second operation accepted without passing through IDLE.
- Reset mid-operation: assert rst_n=0 two edges after start.
  - sum, cout, busy, done, err go to 0 immediately.
  - No done pulse after release; next start completes normally.
